// File: rtl/mmio_bridge_decoder.sv
// mmio_bridge_decoder: decodes CPU word accesses onto NUM_DEV MMIO devices with ack/timeout response
module mmio_bridge_decoder #(
    parameter int BUS_WIDTH     = 32,
    parameter int NUM_DEV       = 4,
    parameter int DEV_ADDR_BITS = 8,
    parameter int BASE_TAG      = 0,
    parameter int TIMEOUT       = 255,
    localparam int AW       = BUS_WIDTH - 2,
    localparam int WBW      = BUS_WIDTH / 8,
    localparam int IDX_BITS = $clog2(NUM_DEV)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cpu_req_valid,
    output logic                         cpu_req_ready,
    input  logic [AW-1:0]                cpu_addr,
    input  logic [BUS_WIDTH-1:0]         cpu_wdata,
    input  logic [WBW-1:0]               cpu_wb,
    output logic                         cpu_resp_valid,
    output logic [BUS_WIDTH-1:0]         cpu_rdata,
    output logic                         cpu_resp_err,
    output logic [NUM_DEV-1:0]           dev_sel,
    output logic [DEV_ADDR_BITS-1:0]     dev_addr,
    output logic [BUS_WIDTH-1:0]         dev_wdata,
    output logic [WBW-1:0]               dev_wb,
    input  logic [NUM_DEV-1:0]           dev_ack,
    input  logic [NUM_DEV*BUS_WIDTH-1:0] dev_rdata
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t               state, state_n;
    logic [IDX_BITS-1:0]  idx, idx_q;
    logic [CW-1:0]        cnt;
    logic                 accept, hit, tag_ok, ack_sel, tmo;
    logic [BUS_WIDTH-1:0] rdata_sel;

    assign idx            = cpu_addr[DEV_ADDR_BITS +: IDX_BITS];
    assign tag_ok         = (cpu_addr >> (DEV_ADDR_BITS + IDX_BITS)) == AW'(BASE_TAG);
    assign hit            = tag_ok && ({1'b0, idx} < (IDX_BITS + 1)'(NUM_DEV));
    assign cpu_req_ready  = (state == IDLE) && !reset;
    assign accept         = cpu_req_valid && cpu_req_ready;
    assign cpu_resp_valid = state == RESP;
    assign dev_sel        = (state == ACCESS) ? (NUM_DEV'(1) << idx_q) : '0;
    assign ack_sel        = dev_ack[idx_q];
    assign rdata_sel      = dev_rdata[int'(idx_q) * BUS_WIDTH +: BUS_WIDTH];
    assign tmo            = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // next-state: a selected ack takes priority over the timeout in the same cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = hit ? ACCESS : ERR;
            ACCESS:  if (ack_sel || tmo) state_n = RESP;
            ERR:     state_n = RESP;
            default: state_n = IDLE;
        endcase
    end

    // request capture, wait counter and response data/err
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q        <= '0;
            cnt          <= '0;
            dev_addr     <= '0;
            dev_wdata    <= '0;
            dev_wb       <= '0;
            cpu_rdata    <= '0;
            cpu_resp_err <= 1'b0;
        end else begin
            if (accept) begin
                idx_q     <= idx;
                cnt       <= '0;
                dev_addr  <= cpu_addr[DEV_ADDR_BITS-1:0];
                dev_wdata <= cpu_wdata;
                dev_wb    <= cpu_wb;
            end
            if (state == ACCESS) begin
                if (ack_sel) begin
                    cpu_rdata    <= (dev_wb == '0) ? rdata_sel : '0;
                    cpu_resp_err <= 1'b0;
                end else if (tmo) begin
                    cpu_rdata    <= '0;
                    cpu_resp_err <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (state == ERR) begin
                cpu_rdata    <= '0;
                cpu_resp_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mmio_bridge_decoder.sv
// tb_mmio_bridge_decoder: directed stimulus with a queued scoreboard checked by a response monitor
module tb_mmio_bridge_decoder;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         cpu_req_valid = 1'b0;
    logic         cpu_req_ready;
    logic [29:0]  cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [3:0]   cpu_wb = '0;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_rdata;
    logic         cpu_resp_err;
    logic [3:0]   dev_sel;
    logic [7:0]   dev_addr;
    logic [31:0]  dev_wdata;
    logic [3:0]   dev_wb;
    logic [3:0]   dev_ack = '0;
    logic [127:0] dev_rdata = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h0BAD_0000};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mmio_bridge_decoder #(.TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wb(cpu_wb),
        .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .cpu_resp_err(cpu_resp_err),
        .dev_sel(dev_sel), .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_wb(dev_wb),
        .dev_ack(dev_ack), .dev_rdata(dev_rdata)
    );

    always #5 clock = ~clock;

    // edge counter used to time responses
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // response monitor: every strobe must match the oldest expectation, in the expected cycle
    always @(negedge clock) begin
        if (cpu_resp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 1, 0);
            end else begin
                e = q.pop_front();
                chk("resp_rdata", cpu_rdata, e.rdata);
                chk("resp_err", cpu_resp_err, e.err);
                chk("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, cpu_req_ready, 0);
        chk({tag, "_resp_valid"}, cpu_resp_valid, 0);
        chk({tag, "_rdata"}, cpu_rdata, 0);
        chk({tag, "_err"}, cpu_resp_err, 0);
        chk({tag, "_dev_sel"}, dev_sel, 0);
        chk({tag, "_dev_addr"}, dev_addr, 0);
        chk({tag, "_dev_wdata"}, dev_wdata, 0);
        chk({tag, "_dev_wb"}, dev_wb, 0);
    endtask

    task automatic issue(input logic [29:0] addr, input logic [31:0] wd, input logic [3:0] wb,
                         output int acc);
        int w = 0;
        cpu_addr = addr;
        cpu_wdata = wd;
        cpu_wb = wb;
        cpu_req_valid = 1'b1;
        @(negedge clock);
        while (!cpu_req_ready && w < 20) begin
            @(negedge clock);
            w++;
        end
        chk("req_ready", cpu_req_ready, 1);
        @(posedge clock);
        #1 cpu_req_valid = 1'b0;
        acc = cyc;
    endtask

    // one transaction; n_acc = ACCESS cycles expected (0 for a decode miss), ack_at = ACCESS cycle of the ack
    task automatic run(input logic [29:0] addr, input logic [31:0] wd, input logic [3:0] wb,
                       input int ack_at, input bit stray, input int n_acc, input logic [3:0] sel,
                       input logic [31:0] er, input logic ee);
        int acc;
        int last;
        exp_t x;
        issue(addr, wd, wb, acc);
        last = (n_acc > 0) ? n_acc : 1;
        x.rdata = er;
        x.err = ee;
        x.cyc = acc + last;
        q.push_back(x);
        for (int k = 0; k <= last; k++) begin
            dev_ack = (k == ack_at) ? sel : ((stray && k < n_acc) ? 4'b0001 : 4'b0000);
            @(negedge clock);
            chk("dev_sel", dev_sel, (k < n_acc) ? sel : 4'b0000);
            chk("busy_ready", cpu_req_ready, 0);
            if (k < n_acc) begin
                chk("dev_addr", dev_addr, addr[7:0]);
                chk("dev_wdata", dev_wdata, wd);
                chk("dev_wb", dev_wb, wb);
            end
            @(posedge clock);
            #1;
        end
        dev_ack = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int acc;
        @(negedge clock);
        check_reset_outputs("reset");
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", cpu_req_ready, 1);
        @(posedge clock);
        #1;
        run(30'h0000_0105, 32'h0, 4'b0000, 0, 1'b0, 1, 4'b0010, 32'hCAFE_F00D, 1'b0);
        run(30'h0000_0310, 32'h1122_3344, 4'b0011, 2, 1'b0, 3, 4'b1000, 32'h0, 1'b0);
        run(30'h0000_0400, 32'h0, 4'b0000, -1, 1'b0, 0, 4'b0000, 32'h0, 1'b1);
        run(30'h0000_0207, 32'h0, 4'b0000, -1, 1'b0, 4, 4'b0100, 32'h0, 1'b1);
        run(30'h0000_020A, 32'h0, 4'b0000, 3, 1'b0, 4, 4'b0100, 32'h2222_2222, 1'b0);
        run(30'h0000_0201, 32'h0, 4'b0000, 2, 1'b1, 3, 4'b0100, 32'h2222_2222, 1'b0);
        run(30'h0000_0105, 32'h0, 4'b0000, 0, 1'b0, 1, 4'b0010, 32'hCAFE_F00D, 1'b0);
        issue(30'h0000_0142, 32'hDEAD_BEEF, 4'b1111, acc);
        @(negedge clock);
        chk("pre_reset_dev_sel", dev_sel, 4'b0010);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("mid_reset");
        #1 reset = 1'b0;
        repeat (6) @(negedge clock);
        chk("idle_after_reset_ready", cpu_req_ready, 1);
        chk("idle_after_reset_sel", dev_sel, 0);
        @(posedge clock);
        #1;
        run(30'h0000_01FF, 32'h0, 4'b0000, 1, 1'b0, 2, 4'b0010, 32'hCAFE_F00D, 1'b0);
        repeat (3) @(negedge clock);
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
